// File: rtl/rifl_rx_buf_pkg.sv
// rifl_rx_buf_pkg
//   Shared types and helpers for the RIFL RX user-side flow-control buffer.
//   - fc_state_t        : flow-control FSM encoding
//   - pause_on_default  : default pause-assert occupancy (2/3 of depth)
//   - pause_off_default : default pause-release occupancy (1/3 of depth)
//   - sat_inc           : saturating increment for counters up to SAT_MAX_W bits
package rifl_rx_buf_pkg;

  typedef enum logic {FC_RUN = 1'b0, FC_PAUSE = 1'b1} fc_state_t;

  localparam int PAUSE_ON_NUM  = 2;
  localparam int PAUSE_OFF_NUM = 1;
  localparam int PAUSE_DEN     = 3;

  localparam int SAT_MAX_W = 64;
  localparam logic [SAT_MAX_W-1:0] SAT_ONE = 64'd1;

  function automatic int pause_on_default(input int depth);
    return (depth * PAUSE_ON_NUM) / PAUSE_DEN;
  endfunction

  function automatic int pause_off_default(input int depth);
    return (depth * PAUSE_OFF_NUM) / PAUSE_DEN;
  endfunction

  // Increment v, holding at the all-ones value of a w-bit counter.
  function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] v,
                                                   input int unsigned w);
    logic [SAT_MAX_W-1:0] max_v;
    if (w >= SAT_MAX_W) max_v = '1;
    else                max_v = (SAT_ONE << w) - SAT_ONE;
    return (v >= max_v) ? v : v + SAT_ONE;
  endfunction

endpackage

// File: rtl/rifl_fwft_reg.sv
// rifl_fwft_reg
//   Registered first-word-fall-through head stage. Loads a new entry whenever
//   it is empty or its current entry is being consumed, so a steady stream
//   passes with no bubbles. Data holds while o_vld=1 and i_rdy=0.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   i_data/i_vld     candidate entry from the buffer side
//   o_rdy            head will capture i_data this cycle if i_vld=1
//   o_data/o_vld     registered head entry towards the consumer
//   i_rdy            consumer ready
module rifl_fwft_reg #(
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] i_data,
  input  logic              i_vld,
  output logic              o_rdy,
  output logic [DWIDTH-1:0] o_data,
  output logic              o_vld,
  input  logic              i_rdy
);

  logic [DWIDTH-1:0] r_data;
  logic              r_vld;
  logic              w_load;

  assign o_rdy  = ~r_vld | i_rdy;
  assign w_load = i_vld & o_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
      r_vld  <= 1'b0;
    end else if (w_load) begin
      r_data <= i_data;
      r_vld  <= 1'b1;
    end else if (i_rdy) begin
      r_vld  <= 1'b0;
    end
  end

  assign o_data = r_data;
  assign o_vld  = r_vld;

endmodule

// File: rtl/rifl_rx_fc_buffer.sv
// rifl_rx_fc_buffer
//   Single-clock RX user buffer with hysteretic pause generation, overflow
//   drop accounting and a peak-occupancy monitor. Entries live in a RAM plus
//   one registered FWFT head; fifo_cnt counts both.
//   Build option RIFL_RX_BUF_STATS_EN enables saturating accepted/dropped
//   write counters; without it those ports are tied to zero.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   s_data, s_vld            write side, no backpressure
//   m_data, m_vld, m_rdy     registered read side
//   fifo_cnt                 occupancy 0..DEPTH
//   rx_up_user               1 = accepting, 0 = pause requested
//   ovf_err                  sticky, set on first dropped write
//   peak_cnt                 highest fifo_cnt since reset
//   frame_in_cnt             accepted writes (stats build)
//   frame_drop_cnt           dropped writes (stats build)
module rifl_rx_fc_buffer
  import rifl_rx_buf_pkg::*;
#(
  parameter int DWIDTH        = 289,
  parameter int DEPTH         = 512,
  parameter int PAUSE_ON_VAL  = pause_on_default(DEPTH),
  parameter int PAUSE_OFF_VAL = pause_off_default(DEPTH),
  parameter int CNT_WIDTH     = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DWIDTH-1:0]      s_data,
  input  logic                   s_vld,
  output logic [DWIDTH-1:0]      m_data,
  output logic                   m_vld,
  input  logic                   m_rdy,
  output logic [$clog2(DEPTH):0] fifo_cnt,
  output logic                   rx_up_user,
  output logic                   ovf_err,
  output logic [$clog2(DEPTH):0] peak_cnt,
  output logic [CNT_WIDTH-1:0]   frame_in_cnt,
  output logic [CNT_WIDTH-1:0]   frame_drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ON_C    = CW'(PAUSE_ON_VAL);
  localparam logic [CW-1:0] OFF_C   = CW'(PAUSE_OFF_VAL);

  if (!((PAUSE_OFF_VAL < PAUSE_ON_VAL) && (PAUSE_ON_VAL <= DEPTH))) begin : g_bad_thr
    $error("rifl_rx_fc_buffer: thresholds must satisfy OFF < ON <= DEPTH");
  end
  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("rifl_rx_fc_buffer: DEPTH must be a power of two and at least 4");
  end

  logic [DWIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]     r_cnt, r_peak;
  logic              r_ovf;
  fc_state_t         r_fc_state, w_fc_next;

  logic              w_ram_empty, w_ram_full;
  logic              w_pop, w_push, w_drop;
  logic              w_src_vld, w_head_rdy;
  logic [DWIDTH-1:0] w_src_data;
  logic              w_ram_rd, w_ram_wr;

  assign w_ram_empty = (r_wr_ptr == r_rd_ptr);
  assign w_ram_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                       (r_wr_ptr[AW] != r_rd_ptr[AW]);

  // A full buffer still accepts a write when the head is popped in the same cycle.
  assign w_pop  = m_vld & m_rdy;
  assign w_push = s_vld & ((r_cnt != DEPTH_C) | w_pop);
  assign w_drop = s_vld & ~w_push;

  // Head is fed from the RAM when it holds anything; otherwise the incoming
  // write bypasses the RAM so an empty buffer has one-cycle latency.
  assign w_src_vld  = ~w_ram_empty | w_push;
  assign w_src_data = w_ram_empty ? s_data : r_mem[r_rd_ptr[AW-1:0]];
  assign w_ram_rd   = w_src_vld & w_head_rdy & ~w_ram_empty;
  assign w_ram_wr   = w_push & ~(w_ram_empty & w_head_rdy) & ~w_ram_full;

  rifl_fwft_reg #(.DWIDTH(DWIDTH)) u_head (
    .clk    (clk),
    .rst    (rst),
    .i_data (w_src_data),
    .i_vld  (w_src_vld),
    .o_rdy  (w_head_rdy),
    .o_data (m_data),
    .o_vld  (m_vld),
    .i_rdy  (m_rdy)
  );

  always_ff @(posedge clk) begin
    if (w_ram_wr) r_mem[r_wr_ptr[AW-1:0]] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_peak   <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_ram_wr) r_wr_ptr <= r_wr_ptr + CW'(1);
      if (w_ram_rd) r_rd_ptr <= r_rd_ptr + CW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (r_cnt > r_peak) r_peak <= r_cnt;
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  // Flow-control FSM
  always_ff @(posedge clk) begin
    if (rst) r_fc_state <= FC_RUN;
    else     r_fc_state <= w_fc_next;
  end

  always_comb begin
    w_fc_next = r_fc_state;
    case (r_fc_state)
      FC_RUN:   if (r_cnt >= ON_C)  w_fc_next = FC_PAUSE;
      FC_PAUSE: if (r_cnt <= OFF_C) w_fc_next = FC_RUN;
    endcase
  end

  always_comb begin
    rx_up_user = (r_fc_state == FC_RUN);
  end

`ifdef RIFL_RX_BUF_STATS_EN
  logic [CNT_WIDTH-1:0] r_in_cnt, r_drop_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_cnt   <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push) r_in_cnt   <= CNT_WIDTH'(sat_inc(SAT_MAX_W'(r_in_cnt), CNT_WIDTH));
      if (w_drop) r_drop_cnt <= CNT_WIDTH'(sat_inc(SAT_MAX_W'(r_drop_cnt), CNT_WIDTH));
    end
  end

  assign frame_in_cnt   = r_in_cnt;
  assign frame_drop_cnt = r_drop_cnt;
`else
  assign frame_in_cnt   = '0;
  assign frame_drop_cnt = '0;
`endif

  assign fifo_cnt = r_cnt;
  assign peak_cnt = r_peak;
  assign ovf_err  = r_ovf;

endmodule

// File: tb/tb_rifl_rx_fc_buffer.sv
// tb_rifl_rx_fc_buffer
//   Self-checking bench for rifl_rx_fc_buffer (DEPTH=16, ON=10, OFF=5).
//   A reference model with an expected-data queue tracks occupancy, pause
//   state, overflow, peak and statistics; every cycle the DUT outputs are
//   compared against it.
module tb_rifl_rx_fc_buffer;

  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int ON    = 10;
  localparam int OFF   = 5;
`ifdef RIFL_RX_BUF_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_data = '0;
  logic          s_vld = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_vld;
  logic          m_rdy = 1'b0;
  logic [4:0]    fifo_cnt;
  logic          rx_up_user;
  logic          ovf_err;
  logic [4:0]    peak_cnt;
  logic [31:0]   frame_in_cnt;
  logic [31:0]   frame_drop_cnt;

  always #5 clk = ~clk;

  rifl_rx_fc_buffer #(
    .DWIDTH        (DW),
    .DEPTH         (DEPTH),
    .PAUSE_ON_VAL  (ON),
    .PAUSE_OFF_VAL (OFF),
    .CNT_WIDTH     (32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .s_data         (s_data),
    .s_vld          (s_vld),
    .m_data         (m_data),
    .m_vld          (m_vld),
    .m_rdy          (m_rdy),
    .fifo_cnt       (fifo_cnt),
    .rx_up_user     (rx_up_user),
    .ovf_err        (ovf_err),
    .peak_cnt       (peak_cnt),
    .frame_in_cnt   (frame_in_cnt),
    .frame_drop_cnt (frame_drop_cnt)
  );

  int            n_chk  = 0;
  int            n_fail = 0;
  logic [DW-1:0] sb_q [$];
  int            m_cnt  = 0;
  int            m_peak = 0;
  bit            m_up   = 1'b1;
  bit            m_ovf  = 1'b0;
  longint        m_in   = 0;
  longint        m_drop = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_outputs();
    chk("fifo_cnt", fifo_cnt, m_cnt);
    chk("m_vld", m_vld, (m_cnt > 0));
    if (m_cnt > 0) chk("m_data", m_data, sb_q[0]);
    chk("rx_up_user", rx_up_user, m_up);
    chk("ovf_err", ovf_err, m_ovf);
    chk("peak_cnt", peak_cnt, m_peak);
    chk("frame_in_cnt", frame_in_cnt, STATS ? m_in : 0);
    chk("frame_drop_cnt", frame_drop_cnt, STATS ? m_drop : 0);
  endtask

  // One clock: check current outputs, drive inputs, advance model past the edge.
  task automatic step(input bit sv, input logic [DW-1:0] sd, input bit rdy);
    bit pop, push, drop;
    chk_outputs();
    s_vld  = sv;
    s_data = sd;
    m_rdy  = rdy;
    pop  = (m_cnt > 0) && rdy;
    push = sv && ((m_cnt < DEPTH) || pop);
    drop = sv && !push;
    @(posedge clk);
    #1;
    if (m_up && (m_cnt >= ON))        m_up = 1'b0;
    else if (!m_up && (m_cnt <= OFF)) m_up = 1'b1;
    if (m_cnt > m_peak) m_peak = m_cnt;
    if (pop)  void'(sb_q.pop_front());
    if (push) begin
      sb_q.push_back(sd);
      m_in++;
    end
    if (drop) begin
      m_ovf = 1'b1;
      m_drop++;
    end
    m_cnt = m_cnt + int'(push) - int'(pop);
    s_vld = 1'b0;
    m_rdy = 1'b0;
  endtask

  task automatic do_reset(input bit wr_during);
    rst    = 1'b1;
    s_vld  = wr_during;
    s_data = 16'hDEAD;
    m_rdy  = 1'b0;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    s_vld = 1'b0;
    sb_q.delete();
    m_cnt  = 0;
    m_peak = 0;
    m_up   = 1'b1;
    m_ovf  = 1'b0;
    m_in   = 0;
    m_drop = 0;
  endtask

  initial begin
    int pw, pr;
    repeat (2) @(posedge clk);
    #1;
    do_reset(1'b0);
    step(1'b0, '0, 1'b0);

    // single entry into empty buffer, held for 3 cycles, then popped
    step(1'b1, 16'h00A5, 1'b0);
    chk("a5_vld", m_vld, 1);
    chk("a5_data", m_data, 16'h00A5);
    repeat (3) step(1'b0, '0, 1'b0);
    chk("a5_hold", m_data, 16'h00A5);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    // pause hysteresis: 10 writes then 5 pops
    for (int i = 0; i < 10; i++) step(1'b1, DW'(16'h0100 + i), 1'b0);
    chk("on_cnt", fifo_cnt, 10);
    chk("on_up_lag", rx_up_user, 1);
    step(1'b0, '0, 1'b0);
    chk("on_paused", rx_up_user, 0);
    repeat (2) step(1'b0, '0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);
    chk("off_cnt", fifo_cnt, 5);
    chk("off_up_lag", rx_up_user, 0);
    step(1'b0, '0, 1'b0);
    chk("off_released", rx_up_user, 1);

    // fill to 16, then two writes that must be dropped
    for (int i = 0; i < 11; i++) step(1'b1, DW'(16'h0200 + i), 1'b0);
    chk("full_cnt", fifo_cnt, 16);
    step(1'b1, 16'hBAD0, 1'b0);
    step(1'b1, 16'hBAD1, 1'b0);
    step(1'b0, '0, 1'b0);
    chk("ovf_set", ovf_err, 1);
    chk("drop_cnt", frame_drop_cnt, STATS ? 2 : 0);
    chk("full_hold", fifo_cnt, 16);

    // push and pop together while full
    step(1'b1, 16'h0300, 1'b1);
    chk("full_pp_cnt", fifo_cnt, 16);
    chk("full_pp_drop", frame_drop_cnt, STATS ? 2 : 0);
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1);
    chk("drained", fifo_cnt, 0);

    // streaming with a single entry in flight
    for (int i = 0; i < 8; i++) step(1'b1, DW'(16'h0400 + i), 1'b1);
    step(1'b0, '0, 1'b1);

    // reset with 7 entries queued and a write on the reset cycle
    for (int i = 0; i < 7; i++) step(1'b1, DW'(16'h0500 + i), 1'b0);
    do_reset(1'b1);
    chk("rst_m_vld", m_vld, 0);
    chk("rst_cnt", fifo_cnt, 0);
    chk("rst_up", rx_up_user, 1);
    chk("rst_ovf", ovf_err, 0);
    chk("rst_peak", peak_cnt, 0);
    repeat (2) step(1'b0, '0, 1'b0);

    // random traffic with drifting bias so the buffer swings through all regions
    for (int c = 0; c < 10000; c++) begin
      case ((c / 400) % 3)
        0:       begin pw = 75; pr = 30; end
        1:       begin pw = 50; pr = 50; end
        default: begin pw = 25; pr = 75; end
      endcase
      step(($urandom_range(99) < pw), DW'($urandom), ($urandom_range(99) < pr));
    end
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1);
    chk("final_cnt", fifo_cnt, 0);
    chk("final_peak", peak_cnt, m_peak);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rifl_rx_fc_buffer.md
Name: rifl_rx_fc_buffer

Overview:
Single-clock receive user buffer with hysteretic pause generation, parametrised in depth, width and thresholds. It replaces the fixed 2/3–1/3 buffer-plus-pause logic at the RIFL RX user side and runs in the tx_frame_clk domain after rifl_decode. It adds overflow detection with drop accounting, a registered first-word-fall-through output, and a peak-occupancy monitor.

Parameters:
DWIDTH, 289, packed entry width ({flag, keep, data} for FRAME_WIDTH=256)
DEPTH, 512, total entry capacity; power of two, at least 4
PAUSE_ON_VAL, 2*DEPTH/3, occupancy at or above which pause is requested
PAUSE_OFF_VAL, DEPTH/3, occupancy at or below which pause is released
CNT_WIDTH, 32, width of the statistics counters

Ports:
clk  in  1  buffer clock (tx_frame_clk domain)
rst  in  1  synchronous, active-high reset
s_data  in  DWIDTH  write entry
s_vld  in  1  write strobe; no backpressure, producer never stalls
m_data  out  DWIDTH  head entry, registered
m_vld  out  1  head valid
m_rdy  in  1  consumer ready
fifo_cnt  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH, includes the output register
rx_up_user  out  1  1 = accepting; 0 = pause requested
ovf_err  out  1  sticky; set on the first dropped write
peak_cnt  out  $clog2(DEPTH)+1  highest fifo_cnt since reset
frame_in_cnt  out  CNT_WIDTH  accepted writes (statistics feature)
frame_drop_cnt  out  CNT_WIDTH  dropped writes (statistics feature)

Behaviour:
- Reset values: m_vld=0, m_data=0, fifo_cnt=0, rx_up_user=1, ovf_err=0, peak_cnt=0, all statistics counters 0. Pointers and FSM return to their initial state. Memory contents are don't-care.
- Pop: occurs when m_vld & m_rdy. m_data must hold stable while m_vld=1 and m_rdy=0.
- Push acceptance: a write is accepted when s_vld=1 and either fifo_cnt<DEPTH, or fifo_cnt==DEPTH with a pop in the same cycle. Otherwise the write is dropped, ovf_err is set next cycle, and frame_drop_cnt increments.
- Latency: a write into an empty buffer gives m_vld=1 with that data on the next cycle. Back-to-back push and pop with 1 entry keeps m_vld=1 continuously with no bubble.
- Occupancy: fifo_cnt updates the cycle after the event. The net change is +1 for a push, -1 for a pop, and 0 for a simultaneous push and pop.
- Ordering: strict FIFO order; no entry is duplicated or lost except writes dropped on overflow.
- Pointers: $clog2(DEPTH)+1 bits with MSB wrap; full when the addresses are equal and the MSBs differ.
- Flow-control FSM: two states, FC_RUN (rx_up_user=1) and FC_PAUSE (rx_up_user=0).
  - FC_RUN to FC_PAUSE when the registered fifo_cnt >= PAUSE_ON_VAL.
  - FC_PAUSE to FC_RUN when fifo_cnt <= PAUSE_OFF_VAL.
  - Between the thresholds the FSM holds its state.
  - rx_up_user changes one cycle after fifo_cnt crosses a threshold.
- peak_cnt: updated to fifo_cnt whenever fifo_cnt > peak_cnt; never decreases until rst.
- Elaboration check: $error if the condition PAUSE_OFF_VAL < PAUSE_ON_VAL <= DEPTH fails, or if DEPTH is not a power of two.
- Reset mid-operation: all queued entries are discarded. m_vld=0 in the cycle after rst is sampled. A write coinciding with rst is ignored.

Optional Feature:
Macro RIFL_RX_BUF_STATS_EN.
- Defined: frame_in_cnt and frame_drop_cnt count accepted and dropped writes, saturating at all-ones (no wrap).
- Undefined: both ports are tied to 0 and no counter flops are synthesised. ovf_err and peak_cnt remain present in both builds.

Decomposition:
- Package rifl_rx_buf_pkg holds:
  - typedef enum logic {FC_RUN, FC_PAUSE} fc_state_t;
  - function sat_inc(), a saturating increment;
  - the threshold default-derivation constants.
- One sub-module, rifl_fwft_reg: the output register stage (skid/FWFT head register with its valid/ready logic). The RAM and pointers stay in the top.

Test Plan:
DEPTH=16, ON=10, OFF=5; write 10 entries with m_rdy=0 -> fifo_cnt=10, rx_up_user falls 1 cycle later; pop 5 -> rx_up_user rises when fifo_cnt=5.
Single write of 0xA5 into empty buffer -> m_vld=1, m_data=0xA5 next cycle; hold m_rdy=0 for 3 cycles -> data stable.
Fill to 16, then s_vld=1 for 2 cycles with m_rdy=0 -> ovf_err=1, frame_drop_cnt=2, fifo_cnt stays 16, read-out order intact.
At fifo_cnt=16, s_vld=1 and m_rdy=1 together -> write accepted, fifo_cnt stays 16, no drop.
Random push/pop for 10k cycles vs scoreboard -> exact order match; peak_cnt equals model maximum; no m_vld bubble while occupancy > 0.
Assert rst with 7 entries queued -> next cycle m_vld=0, fifo_cnt=0, rx_up_user=1, ovf_err=0, peak_cnt=0.
